dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 17 +
 rtl/trace_fifo.sv | 48 ++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam logic [31:0] BUS_ERR_CODE = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with sticky overflow flag; a push while full is dropped unless a pop frees a slot.
module trace_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ovf
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wptr;
    logic [PW:0]      rptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr[PW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + (PW+1)'(1);
            if (do_pop)  rptr <= rptr + (PW+1)'(1);
            if (push && !do_push) ovf <= 1'b1;
        end
    end

    // Storage is not reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the single-cycle core: word RAM, tohost verdict register,
// and an optional store-trace FIFO enabled by `define DMEM_TRACE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter logic [31:0] TOHOST_ADDR = 32'd100,
    parameter logic [31:0] PASS_CODE   = 32'd25,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic [31:0] fail_code
`ifdef DMEM_TRACE_EN
    ,
    output logic        trace_valid,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    input  logic        trace_pop,
    output logic        trace_ovf
`endif
);

    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    logic [31:0]      ram [DEPTH];
    state_e           state_q;
    state_e           state_d;
    logic [31:0]      fail_code_d;
    logic             ram_we;
    logic             aligned;
    logic             in_range;
    logic             is_tohost;
    logic [IDX_W-1:0] idx;

    assign aligned   = (DataAdr[1:0] == 2'b00);
    assign in_range  = (DataAdr < RAM_BYTES);
    assign is_tohost = (DataAdr == TOHOST_ADDR);
    assign idx       = DataAdr[IDX_W+1:2];

    // Status register decode takes priority over the RAM window it may overlap.
    always_comb begin
        state_d     = state_q;
        fail_code_d = fail_code;
        ram_we      = 1'b0;
        if (state_q == ST_RUN && MemWrite) begin
            if (!aligned) begin
                state_d     = ST_FAIL;
                fail_code_d = BUS_ERR_CODE;
            end else if (is_tohost) begin
                if (WriteData == PASS_CODE) begin
                    state_d = ST_PASS;
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = WriteData;
                end
            end else if (in_range) begin
                ram_we = 1'b1;
            end else begin
                state_d     = ST_FAIL;
                fail_code_d = BUS_ERR_CODE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= '0;
        end else begin
            state_q   <= state_d;
            done      <= (state_d != ST_RUN);
            pass      <= (state_d == ST_PASS);
            fail_code <= fail_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx] <= WriteData;
    end

    always_comb begin
        ReadData = '0;
        if (is_tohost)               ReadData = {30'b0, pass, done};
        else if (aligned && in_range) ReadData = ram[idx];
    end

`ifdef DMEM_TRACE_EN
    trace_entry_t entry_in;
    trace_entry_t entry_out;
    logic         trace_push;
    logic         trace_empty;

    assign trace_push = (state_q == ST_RUN) && MemWrite;
    assign entry_in   = '{addr: DataAdr, data: WriteData};

    trace_fifo #(
        .WIDTH ($bits(trace_entry_t)),
        .DEPTH (TRACE_DEPTH)
    ) u_trace (
        .clk   (clk),
        .rst   (reset),
        .push  (trace_push),
        .pop   (trace_pop),
        .din   (entry_in),
        .dout  (entry_out),
        .empty (trace_empty),
        .ovf   (trace_ovf)
    );

    assign trace_valid = !trace_empty;
    assign trace_addr  = entry_out.addr;
    assign trace_data  = entry_out.data;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a behavioural memory/verdict model.
module tb_dmem_responder;

    localparam int unsigned DEPTH       = 64;
    localparam int unsigned TRACE_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        done;
    logic        pass;
    logic [31:0] fail_code;
`ifdef DMEM_TRACE_EN
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        trace_pop = 1'b0;
    logic        trace_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_ram [DEPTH];
    bit          m_known [DEPTH];
    bit          m_done;
    bit          m_pass;
    logic [31:0] m_code;
    logic [63:0] m_q [$];
    bit          m_ovf;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .DataAdr    (DataAdr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .done       (done),
        .pass       (pass),
        .fail_code  (fail_code)
`ifdef DMEM_TRACE_EN
        ,
        .trace_valid(trace_valid),
        .trace_addr (trace_addr),
        .trace_data (trace_data),
        .trace_pop  (trace_pop),
        .trace_ovf  (trace_ovf)
`endif
    );

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a == 32'd100) return {30'b0, m_pass, m_done};
        if (a[1:0] == 2'b00 && a < 32'(4 * DEPTH)) return m_ram[a[7:2]];
        return 32'd0;
    endfunction

    task automatic model_clear();
        m_done = 0; m_pass = 0; m_code = '0; m_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        if (m_done) return;
        if (m_q.size() < TRACE_DEPTH) m_q.push_back({a, d});
        else m_ovf = 1;
        if (a[1:0] != 2'b00) begin
            m_done = 1; m_code = 32'hFFFF_FFFF;
        end else if (a == 32'd100) begin
            m_done = 1;
            m_pass = (d == 32'd25);
            if (!m_pass) m_code = d;
        end else if (a < 32'(4 * DEPTH)) begin
            m_ram[a[7:2]] = d; m_known[a[7:2]] = 1;
        end else begin
            m_done = 1; m_code = 32'hFFFF_FFFF;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: optional store and optional trace pop, sampled 1 ns after the edge.
    task automatic cycle(input bit we, input logic [31:0] a, input logic [31:0] d, input bit pop);
        @(negedge clk);
        MemWrite = we; DataAdr = a; WriteData = d;
`ifdef DMEM_TRACE_EN
        trace_pop = pop;
`endif
        @(posedge clk);
        if (pop && m_q.size() > 0) void'(m_q.pop_front());
        if (we) model_store(a, d);
        #1;
        MemWrite = 1'b0;
`ifdef DMEM_TRACE_EN
        trace_pop = 1'b0;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_clear();
        #22;
        reset = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b0) begin
            errors++; $display("FAIL reset_flags: done=%b pass=%b required 0 0", done, pass);
        end
        checks++;
        if (fail_code !== 32'd0) begin
            errors++; $display("FAIL reset_fail_code: got %h required 0", fail_code);
        end
`ifdef DMEM_TRACE_EN
        checks++;
        if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_trace: valid=%b ovf=%b required 0 0", trace_valid, trace_ovf);
        end
`endif
    endtask

    task automatic test_store_load();
        logic [31:0] a;
        cycle(1, 32'd96, 32'd7, 0);
        DataAdr = 32'd96;
        #1;
        checks++;
        if (ReadData !== 32'd7 || done !== 1'b0) begin
            errors++; $display("FAIL store96: ReadData=%0d done=%b required 7 0", ReadData, done);
        end
        for (int i = 0; i < 16; i++) begin
            int unsigned k;
            k = $urandom_range(0, DEPTH - 1);
            if (k == 25 || k == 24) k = 0;
            cycle(1, 32'(k * 4), $urandom, 0);
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (!m_known[k] || k == 25) continue;
            a = 32'(k * 4);
            @(negedge clk);
            DataAdr = a;
            #1;
            checks++;
            if (ReadData !== exp_read(a)) begin
                errors++; $display("FAIL load_%0d: got %h required %h", a, ReadData, exp_read(a));
            end
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL run_after_stores: done=%b required 0", done);
        end
    endtask

    task automatic test_pass();
        apply_reset();
        cycle(1, 32'd100, 32'd25, 0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++; $display("FAIL pass_verdict: done=%b pass=%b required 1 1", done, pass);
        end
        DataAdr = 32'd100;
        #1;
        checks++;
        if (ReadData !== 32'd3) begin
            errors++; $display("FAIL tohost_read_pass: got %h required 3", ReadData);
        end
        cycle(1, 32'd96, 32'hDEAD_BEEF, 0);
        DataAdr = 32'd96;
        #1;
        checks++;
        if (ReadData !== 32'd7) begin
            errors++; $display("FAIL ram_frozen: got %h required 7", ReadData);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            errors++; $display("FAIL pass_absorbing: done=%b pass=%b required 1 1", done, pass);
        end
    endtask

    task automatic test_fail_code();
        logic [31:0] d;
        apply_reset();
        cycle(1, 32'd100, 32'd24, 0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 32'd24) begin
            errors++; $display("FAIL fail_24: done=%b pass=%b code=%h required 1 0 18", done, pass, fail_code);
        end
        apply_reset();
        d = $urandom;
        if (d == 32'd25) d = 32'd26;
        cycle(1, 32'd100, d, 0);
        DataAdr = 32'd100;
        #1;
        checks++;
        if (fail_code !== m_code || ReadData !== exp_read(32'd100)) begin
            errors++; $display("FAIL fail_rand: code=%h rd=%h required %h %h", fail_code, ReadData, m_code, exp_read(32'd100));
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] a;
        apply_reset();
        cycle(1, 32'd98, $urandom, 0);
        DataAdr = 32'd96;
        #1;
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail_code !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL misaligned: done=%b pass=%b code=%h required 1 0 ffffffff", done, pass, fail_code);
        end
        checks++;
        if (ReadData !== exp_read(32'd96)) begin
            errors++; $display("FAIL misaligned_ram: got %h required %h", ReadData, exp_read(32'd96));
        end
        apply_reset();
        cycle(1, 32'(4 * DEPTH), 32'd25, 0);
        checks++;
        if (done !== 1'b1 || fail_code !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL out_of_range: done=%b code=%h required 1 ffffffff", done, fail_code);
        end
        apply_reset();
        a = 32'(4 * DEPTH) + {$urandom_range(0, 1000), 2'b00};
        cycle(1, a, $urandom, 0);
        DataAdr = a;
        #1;
        checks++;
        if (done !== m_done || fail_code !== m_code || ReadData !== 32'd0) begin
            errors++; $display("FAIL out_of_range_rand: done=%b code=%h rd=%h required %b %h 0", done, fail_code, ReadData, m_done, m_code);
        end
    endtask

`ifdef DMEM_TRACE_EN
    task automatic drain_and_check(input string tag, input int expect_n);
        int n;
        n = 0;
        while (trace_valid === 1'b1 && n < 2 * TRACE_DEPTH) begin
            checks++;
            if (m_q.size() == 0 || {trace_addr, trace_data} !== m_q[0]) begin
                errors++;
                $display("FAIL %s_entry%0d: got %h/%h required %h", tag, n, trace_addr, trace_data,
                         (m_q.size() > 0) ? m_q[0] : 64'd0);
            end
            cycle(0, 32'd0, 32'd0, 1);
            n++;
        end
        checks++;
        if (n != expect_n || m_q.size() != 0) begin
            errors++; $display("FAIL %s_count: drained %0d required %0d", tag, n, expect_n);
        end
    endtask

    task automatic test_trace();
        apply_reset();
        for (int i = 0; i < 9; i++) cycle(1, 32'($urandom_range(0, 23) * 4), $urandom, 0);
        checks++;
        if (trace_ovf !== 1'b1 || m_ovf != 1) begin
            errors++; $display("FAIL trace_ovf_set: got %b required 1", trace_ovf);
        end
        drain_and_check("trace9", TRACE_DEPTH);
        cycle(0, 32'd0, 32'd0, 1);
        checks++;
        if (trace_valid !== 1'b0) begin
            errors++; $display("FAIL pop_empty: valid=%b required 0", trace_valid);
        end
        apply_reset();
        for (int i = 0; i < TRACE_DEPTH; i++) cycle(1, 32'($urandom_range(30, 63) * 4), $urandom, 0);
        cycle(1, 32'd4, $urandom, 1);
        checks++;
        if (trace_ovf !== 1'b0) begin
            errors++; $display("FAIL push_pop_full: ovf=%b required 0", trace_ovf);
        end
        drain_and_check("pushpop", TRACE_DEPTH);
        cycle(1, 32'd100, 32'd25, 0);
        cycle(1, 32'd8, 32'd1, 0);
        drain_and_check("terminal", 1);
    endtask
`endif

    task automatic test_reset_midrun();
        apply_reset();
        cycle(1, 32'd0, 32'd5, 0);
        cycle(1, 32'd100, 32'd24, 0);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL pre_reset_done: got %b required 1", done);
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (done !== 1'b0 || pass !== 1'b0 || fail_code !== 32'd0) begin
            errors++; $display("FAIL async_reset: done=%b pass=%b code=%h required 0 0 0", done, pass, fail_code);
        end
`ifdef DMEM_TRACE_EN
        checks++;
        if (trace_valid !== 1'b0 || trace_ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset_trace: valid=%b ovf=%b required 0 0", trace_valid, trace_ovf);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
        DataAdr = 32'd0;
        #1;
        checks++;
        if (ReadData !== 32'd5) begin
            errors++; $display("FAIL ram_kept: got %h required 5", ReadData);
        end
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_ram[k] = '0;
            m_known[k] = 0;
        end
        test_reset();
        test_store_load();
        test_pass();
        test_fail_code();
        test_bus_error();
`ifdef DMEM_TRACE_EN
        test_trace();
`endif
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
